// File: rtl/mulresult_pkg.sv
// mulresult_pkg: shared MDU multiply opcodes, E->M opcode bundle and result-half decode
package mulresult_pkg;

   localparam logic [2:0] MUL_F3    = 3'b000;
   localparam logic [2:0] MULH_F3   = 3'b001;
   localparam logic [2:0] MULHSU_F3 = 3'b010;
   localparam logic [2:0] MULHU_F3  = 3'b011;

   typedef struct packed {
      logic       valid;
      logic [2:0] funct3;
      logic       w64;
   } mulop_t;

   // High-half ops take the upper product word; everything else, including unused 1xx, takes the low word
   function automatic logic is_high(input logic [2:0] f3);
      return f3 == MULH_F3 || f3 == MULHSU_F3 || f3 == MULHU_F3;
   endfunction

endpackage

// File: rtl/flopenrc.sv
// flopenrc: resettable flop with enable and synchronous clear
module flopenrc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Clear only takes effect when enabled, so a stalled stage ignores a flush
   always_ff @(posedge clk)
      if (reset)   q <= '0;
      else if (en) q <= clear ? '0 : d;

endmodule

// File: rtl/mulretcnt.sv
// mulretcnt: wrapping retired-multiply counter with increment enable
module mulretcnt #(
   parameter int CNTW = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   output logic [CNTW-1:0] count
);

   // Wraps naturally modulo 2^CNTW
   always_ff @(posedge clk)
      if (reset)   count <= '0;
      else if (en) count <= count + CNTW'(1);

endmodule

// File: rtl/mulresult.sv
// mulresult: MDU multiply result select, M->W register and retire counter
module mulresult
   import mulresult_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int CNTW = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              StallM,
   input  logic              FlushM,
   input  logic              StallW,
   input  logic              FlushW,
   input  logic              MulValidE,
   input  logic [2:0]        Funct3E,
   input  logic              W64E,
   input  logic [2*XLEN-1:0] ProdM,
   output logic              MulValidM,
   output logic [XLEN-1:0]   MulResultM,
   output logic              MulValidW,
   output logic [XLEN-1:0]   MulResultW,
   output logic [CNTW-1:0]   MulCountW
);

   mulop_t          opm;
   logic            w64m;
   logic [XLEN-1:0] wordres;

   flopenrc #($bits(mulop_t)) emreg (
      .clk   (clk),
      .reset (reset),
      .clear (FlushM),
      .en    (~StallM),
      .d     ({MulValidE, Funct3E, W64E}),
      .q     (opm)
   );

   assign MulValidM = opm.valid;

   generate
      if (XLEN == 64) begin : g_w64
         assign w64m    = opm.w64;
         assign wordres = {{32{ProdM[31]}}, ProdM[31:0]};
      end else begin : g_w32
         assign w64m    = 1'b0;
         assign wordres = ProdM[XLEN-1:0];
      end
   endgenerate

   // Pure mux over the product halves; word ops override the opcode
   always_comb
      MulResultM = w64m ? wordres : is_high(opm.funct3) ? ProdM[2*XLEN-1:XLEN] : ProdM[XLEN-1:0];

   flopenrc #(XLEN + 1) mwreg (
      .clk   (clk),
      .reset (reset),
      .clear (FlushW),
      .en    (~StallW),
      .d     ({MulValidM, MulResultM}),
      .q     ({MulValidW, MulResultW})
   );

   mulretcnt #(CNTW) retcnt (
      .clk   (clk),
      .reset (reset),
      .en    (~StallW & ~FlushW & MulValidM),
      .count (MulCountW)
   );

endmodule

// File: tb/tb_mulresult.sv
// tb_mulresult: randomized scoreboard bench for mulresult against a behavioural pipeline model
module tb_mulresult;

   logic         clk = 1'b0;
   logic         reset, StallM, FlushM, StallW, FlushW, MulValidE, W64E;
   logic [2:0]   Funct3E;
   logic [127:0] ProdM;
   logic         MulValidM, MulValidW;
   logic [63:0]  MulResultM, MulResultW;
   logic [3:0]   MulCountW;

   mulresult #(.XLEN(64), .CNTW(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .StallM     (StallM),
      .FlushM     (FlushM),
      .StallW     (StallW),
      .FlushW     (FlushW),
      .MulValidE  (MulValidE),
      .Funct3E    (Funct3E),
      .W64E       (W64E),
      .ProdM      (ProdM),
      .MulValidM  (MulValidM),
      .MulResultM (MulResultM),
      .MulValidW  (MulValidW),
      .MulResultW (MulResultW),
      .MulCountW  (MulCountW)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        vm;
      logic [63:0] rm;
      logic        vw;
      logic [63:0] rw;
      logic [3:0]  cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   // Behavioural model: the instruction sitting in M, the retired W contents, and a retire tally
   logic        m_valid, m_w64;
   logic [2:0]  m_f3;
   logic        w_valid;
   logic [63:0] w_res;
   int          retired;
   bit          model_ok = 0;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] b);
      checks++;
      if (a !== b) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, a, b);
      end
   endtask

   function automatic logic [63:0] pick(input logic w64, input logic [2:0] f3, input logic [127:0] p);
      logic signed [31:0] word;
      word = p[31:0];
      if (w64) return 64'($signed(word));
      case (f3)
         3'd1, 3'd2, 3'd3: return p[127:64];
         default:          return p[63:0];
      endcase
   endfunction

   task automatic cycle(input bit rst, input bit sm, input bit fm, input bit sw, input bit fw,
                        input bit ve, input logic [2:0] f3, input bit w64, input logic [127:0] prod);
      logic [63:0] rm;
      reset = rst; StallM = sm; FlushM = fm; StallW = sw; FlushW = fw;
      MulValidE = ve; Funct3E = f3; W64E = w64; ProdM = prod;
      #1;
      rm = pick(m_w64, m_f3, prod);
      if (model_ok) q.push_back('{m_valid, rm, w_valid, w_res, 4'(retired % 16)});
      if (rst) begin
         m_valid = 0; m_f3 = 0; m_w64 = 0; w_valid = 0; w_res = 0; retired = 0;
      end else begin
         if (!sw && !fw && m_valid) retired++;
         if (!sw) begin
            w_valid = fw ? 1'b0 : m_valid;
            w_res   = fw ? 64'd0 : rm;
         end
         if (!sm) begin
            m_valid = fm ? 1'b0 : ve;
            m_f3    = fm ? 3'd0 : f3;
            m_w64   = fm ? 1'b0 : w64;
         end
      end
      model_ok = 1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: pops the expected pipeline view and compares it mid-cycle
   always @(negedge clk)
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("valid_m", 64'(MulValidM), 64'(e.vm));
         chk("result_m", MulResultM, e.rm);
         chk("valid_w", 64'(MulValidW), 64'(e.vw));
         chk("result_w", MulResultW, e.rw);
         chk("count_w", 64'(MulCountW), 64'(e.cnt));
      end

   initial begin
      @(posedge clk);
      #1;
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // MULH through M and W
      cycle(0, 0, 0, 0, 0, 1, 3'b001, 0, rnd128());
      cycle(0, 0, 0, 0, 0, 0, 3'b000, 0, 128'h0000_0000_0000_0003_FFFF_FFFF_FFFF_FFFD);
      chk("mulh_w", MulResultW, 64'h3);
      chk("mulh_cnt", 64'(MulCountW), 64'd1);
      // MULW sign extension
      cycle(0, 0, 0, 0, 0, 1, 3'b000, 1, rnd128());
      cycle(0, 0, 0, 0, 0, 0, 3'b000, 0, {64'h1234_5678_9ABC_DEF0, 64'h0000_0001_8000_0000});
      chk("mulw_w", MulResultW, 64'hFFFF_FFFF_8000_0000);
      // W stall for two cycles then release
      cycle(0, 0, 0, 0, 0, 1, 3'b011, 0, rnd128());
      cycle(0, 0, 0, 1, 0, 0, 3'b000, 0, rnd128());
      cycle(0, 0, 0, 1, 1, 0, 3'b000, 0, rnd128());
      cycle(0, 0, 0, 0, 0, 0, 3'b000, 0, rnd128());
      // Flush in M, then a non-multiply
      cycle(0, 0, 1, 0, 0, 1, 3'b001, 0, rnd128());
      cycle(0, 0, 0, 0, 0, 0, 3'b011, 0, rnd128());
      cycle(0, 0, 0, 0, 0, 0, 3'b000, 0, rnd128());
      cycle(0, 0, 0, 0, 0, 0, 3'b000, 0, rnd128());
      // Wrap: clean start then 17 back-to-back multiplies gives 16 retires, one left in M
      cycle(1, 0, 0, 0, 0, 0, 0, 0, rnd128());
      for (int i = 0; i < 17; i++) cycle(0, 0, 0, 0, 0, 1, 3'($urandom_range(0, 7)), 1'($urandom), rnd128());
      chk("wrap_cnt", 64'(MulCountW), 64'd0);
      chk("wrap_vm", 64'(MulValidM), 64'd1);
      chk("wrap_vw", 64'(MulValidW), 64'd1);
      cycle(1, 0, 0, 0, 0, 1, 3'b001, 0, rnd128());
      chk("rst_vm", 64'(MulValidM), 64'd0);
      chk("rst_vw", 64'(MulValidW), 64'd0);
      chk("rst_rw", MulResultW, 64'd0);
      chk("rst_cnt", 64'(MulCountW), 64'd0);
      // Random traffic with stalls, flushes and occasional resets
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70,
               3'($urandom_range(0, 7)), $urandom_range(0, 99) < 30, rnd128());
      cycle(0, 0, 0, 0, 0, 0, 0, 0, rnd128());
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
